// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART receive path.
// The tagged entry is used when UART_RX_FIFO_ERR_TAG_EN is defined.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic                   err;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Purpose: DEPTH x WIDTH register array, synchronous write, asynchronous read.
// Latency: a write is visible on rdata the cycle after the write edge.
// Backpressure: none; the caller must not write a full array.
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Purpose: buffers bytes from uart_rx, drops and counts framing errors, sticky overflow.
// Latency: 1 cycle from push edge into an empty FIFO to out_valid (registered head).
// Backpressure: out_ready stalls the head; a push with no room is dropped and sets overflow.
// Option: UART_RX_FIFO_ERR_TAG_EN stores errored bytes with a tag and adds out_err.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [UART_DATA_W-1:0]    uart_rx_data,
    input  logic                      uart_valid,
    input  logic                      uart_err,
    output logic [UART_DATA_W-1:0]    out_data,
    output logic                      out_valid,
`ifdef UART_RX_FIFO_ERR_TAG_EN
    output logic                      out_err,
`endif
    input  logic                      out_ready,
    output logic [cnt_w(DEPTH)-1:0]   fifo_count,
    output logic                      fifo_full,
    output logic                      overflow,
    output logic [ERR_CNT_W-1:0]      err_count,
    input  logic                      status_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

`ifdef UART_RX_FIFO_ERR_TAG_EN
    typedef rx_entry_t entry_t;
`else
    typedef logic [UART_DATA_W-1:0] entry_t;
`endif

    entry_t          wr_entry;
    entry_t          rd_entry;
    entry_t          head_q;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_nxt;
    logic            push_req;
    logic            pop;
    logic            has_room;
    logic            push_ok;
    logic            ovf_evt;
    logic            mem_empty;
    logic            load_head;
    logic            bypass;
    logic            mem_we;

`ifdef UART_RX_FIFO_ERR_TAG_EN
    assign push_req = uart_valid;
    assign wr_entry = '{err: uart_err, data: uart_rx_data};
    assign out_data = head_q.data;
    assign out_err  = head_q.err;
`else
    assign push_req = uart_valid && !uart_err;
    assign wr_entry = uart_rx_data;
    assign out_data = head_q;
`endif

    // The head register is one of the counted entries, so the array holds
    // fifo_count - out_valid bytes; an empty array lets a push bypass into the head.
    always_comb begin
        pop       = out_valid && out_ready;
        has_room  = !fifo_full || pop;
        push_ok   = push_req && has_room;
        ovf_evt   = push_req && !has_room;
        mem_empty = (fifo_count == CW'(out_valid));
        load_head = !out_valid || pop;
        bypass    = load_head && mem_empty && push_ok;
        mem_we    = push_ok && !bypass;
        count_nxt = fifo_count;
        if (push_ok && !pop) begin
            count_nxt = fifo_count + CW'(1);
        end else if (!push_ok && pop) begin
            count_nxt = fifo_count - CW'(1);
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_q     <= '0;
            out_valid  <= 1'b0;
            fifo_count <= '0;
            fifo_full  <= 1'b0;
            overflow   <= 1'b0;
            err_count  <= '0;
        end else begin
            if (mem_we) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load_head) begin
                if (!mem_empty) begin
                    head_q    <= rd_entry;
                    rd_ptr    <= rd_ptr + AW'(1);
                    out_valid <= 1'b1;
                end else if (push_ok) begin
                    head_q    <= wr_entry;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            fifo_count <= count_nxt;
            fifo_full  <= (count_nxt == DEPTH_C);
            // A same-cycle event beats status_clr.
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (status_clr) begin
                overflow <= 1'b0;
            end
            if (uart_err) begin
                if (status_clr) begin
                    err_count <= ERR_CNT_W'(1);
                end else if (err_count != '1) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
            end else if (status_clr) begin
                err_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed table plus corner-case sequences for uart_rx_fifo (DEPTH=16, ERR_CNT_W=8).
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] uart_rx_data;
    logic       uart_valid;
    logic       uart_err;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] fifo_count;
    logic       fifo_full;
    logic       overflow;
    logic [7:0] err_count;
    logic       status_clr;
`ifdef UART_RX_FIFO_ERR_TAG_EN
    logic       out_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(16), .ERR_CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rx_data (uart_rx_data),
        .uart_valid   (uart_valid),
        .uart_err     (uart_err),
        .out_data     (out_data),
        .out_valid    (out_valid),
`ifdef UART_RX_FIFO_ERR_TAG_EN
        .out_err      (out_err),
`endif
        .out_ready    (out_ready),
        .fifo_count   (fifo_count),
        .fifo_full    (fifo_full),
        .overflow     (overflow),
        .err_count    (err_count),
        .status_clr   (status_clr)
    );

    typedef struct {
        logic       v;
        logic       e;
        logic       r;
        logic       c;
        logic [7:0] d;
        logic       xv;
        logic [7:0] xd;
        logic [4:0] xc;
        logic       xf;
        logic       xo;
        logic [7:0] xe;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(input logic v, input logic e, input logic r, input logic c,
                                input logic [7:0] d, input logic xv, input logic [7:0] xd,
                                input logic [4:0] xc, input logic xf, input logic xo,
                                input logic [7:0] xe);
        vec_t t;
        t.v = v; t.e = e; t.r = r; t.c = c; t.d = d;
        t.xv = xv; t.xd = xd; t.xc = xc; t.xf = xf; t.xo = xo; t.xe = xe;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic e, input logic r, input logic c,
                         input logic [7:0] d);
        uart_valid   = v;
        uart_err     = e;
        out_ready    = r;
        status_clr   = c;
        uart_rx_data = d;
    endtask

    task automatic check_state(input string tag, input logic xv, input logic [4:0] xc,
                               input logic xf, input logic xo, input logic [7:0] xe);
        check({tag, ".out_valid"},  32'(out_valid),  32'(xv));
        check({tag, ".fifo_count"}, 32'(fifo_count), 32'(xc));
        check({tag, ".fifo_full"},  32'(fifo_full),  32'(xf));
        check({tag, ".overflow"},   32'(overflow),   32'(xo));
        check({tag, ".err_count"},  32'(err_count),  32'(xe));
    endtask

    initial begin
        //             v  e  r  c  data    xv  xd     xc     xf xo xe
        tbl[0]  = mk(1, 0, 0, 0, 8'h34, 1, 8'h34, 5'd1, 0, 0, 8'd0);
        tbl[1]  = mk(0, 0, 1, 0, 8'h00, 0, 8'h00, 5'd0, 0, 0, 8'd0);
        tbl[2]  = mk(1, 0, 1, 0, 8'h34, 1, 8'h34, 5'd1, 0, 0, 8'd0);
        tbl[3]  = mk(1, 0, 1, 0, 8'h55, 1, 8'h55, 5'd1, 0, 0, 8'd0);
        tbl[4]  = mk(1, 0, 1, 0, 8'h5A, 1, 8'h5A, 5'd1, 0, 0, 8'd0);
        tbl[5]  = mk(0, 0, 1, 0, 8'h00, 0, 8'h00, 5'd0, 0, 0, 8'd0);
        tbl[6]  = mk(1, 1, 0, 0, 8'h77, 0, 8'h00, 5'd0, 0, 0, 8'd1);
        tbl[7]  = mk(0, 1, 0, 1, 8'h00, 0, 8'h00, 5'd0, 0, 0, 8'd1);
        tbl[8]  = mk(0, 0, 0, 1, 8'h00, 0, 8'h00, 5'd0, 0, 0, 8'd0);
        tbl[9]  = mk(1, 0, 0, 1, 8'h12, 1, 8'h12, 5'd1, 0, 0, 8'd0);
        tbl[10] = mk(1, 0, 0, 0, 8'h13, 1, 8'h12, 5'd2, 0, 0, 8'd0);
        tbl[11] = mk(0, 0, 1, 0, 8'h00, 1, 8'h13, 5'd1, 0, 0, 8'd0);
        tbl[12] = mk(0, 0, 1, 0, 8'h00, 0, 8'h00, 5'd0, 0, 0, 8'd0);

        reset = 1'b1;
        drive(0, 0, 0, 0, 8'h00);
        tick();
        tick();
        check_state("reset", 0, 5'd0, 0, 0, 8'd0);
        check("reset.out_data", 32'(out_data), 32'h00);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].e, tbl[i].r, tbl[i].c, tbl[i].d);
            tick();
            check_state($sformatf("vec%0d", i), tbl[i].xv, tbl[i].xc, tbl[i].xf, tbl[i].xo, tbl[i].xe);
            if (tbl[i].xv) begin
                check($sformatf("vec%0d.out_data", i), 32'(out_data), 32'(tbl[i].xd));
            end
        end

        // Fill to DEPTH, overflow, clear, then push+pop while full.
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 0, 8'(i));
            tick();
        end
        check_state("fill", 1, 5'd16, 1, 0, 8'd0);
        check("fill.out_data", 32'(out_data), 32'h00);
        drive(1, 0, 0, 0, 8'hAA);
        tick();
        check_state("ovf", 1, 5'd16, 1, 1, 8'd0);
        check("ovf.out_data", 32'(out_data), 32'h00);
        drive(0, 0, 0, 1, 8'h00);
        tick();
        check_state("ovf_clr", 1, 5'd16, 1, 0, 8'd0);
        drive(1, 0, 1, 0, 8'hC3);
        tick();
        check_state("full_pushpop", 1, 5'd16, 1, 0, 8'd0);
        check("full_pushpop.out_data", 32'(out_data), 32'h01);

        drive(0, 0, 1, 0, 8'h00);
        for (int k = 0; k < 16; k++) begin
            logic [7:0] exp_b;
            exp_b = (k < 15) ? 8'(k + 1) : 8'hC3;
            check($sformatf("drain%0d.out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("drain%0d.out_data", k), 32'(out_data), 32'(exp_b));
            check($sformatf("drain%0d.fifo_count", k), 32'(fifo_count), 32'(16 - k));
            tick();
        end
        check_state("drained", 0, 5'd0, 0, 0, 8'd0);

        drive(1, 0, 0, 0, 8'h55);
        tick();
        check_state("refill", 1, 5'd1, 0, 0, 8'd0);
        check("refill.out_data", 32'(out_data), 32'h55);
        drive(0, 0, 1, 0, 8'h00);
        tick();
        check_state("refill_pop", 0, 5'd0, 0, 0, 8'd0);

        // Error counter saturation and clear.
        drive(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 255; i++) tick();
        check("sat255.err_count", 32'(err_count), 32'd255);
        for (int i = 0; i < 45; i++) tick();
        check("sat300.err_count", 32'(err_count), 32'd255);
        drive(0, 0, 0, 1, 8'h00);
        tick();
        check_state("err_clr", 0, 5'd0, 0, 0, 8'd0);

        // Reset mid-stream with a push in flight.
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 8'hA0 + 8'(i));
            tick();
        end
        drive(0, 1, 0, 0, 8'h00);
        tick();
        check_state("pre_reset", 1, 5'd5, 0, 0, 8'd1);
        drive(1, 0, 0, 0, 8'hEE);
        reset = 1'b1;
        tick();
        check_state("mid_reset", 0, 5'd0, 0, 0, 8'd0);
        check("mid_reset.out_data", 32'(out_data), 32'h00);
        reset = 1'b0;
        drive(0, 0, 1, 0, 8'h00);
        tick();
        check_state("post_reset", 0, 5'd0, 0, 0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of uart_rx.
- Captures each byte that uart_rx reports as valid, stores it in a circular FIFO, and presents it to the consumer over a valid/ready interface.
- Discards framing-error bytes and counts them; flags overflow when a byte arrives with no space.
- Decouples UART byte timing from host/consumer read timing.

Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- ERR_CNT_W, 8, width of the saturating framing-error counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- uart_rx_data  input  8  received byte from uart_rx; sampled only when uart_valid=1.
- uart_valid  input  1  single-cycle strobe: uart_rx_data holds a completed frame.
- uart_err  input  1  single-cycle strobe: framing error (bad stop bit).
- out_data  output  8  byte at the FIFO head.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the head byte when out_valid=1 and out_ready=1 in the same cycle.
- fifo_count  output  $clog2(DEPTH)+1  number of stored entries.
- fifo_full  output  1  fifo_count == DEPTH.
- overflow  output  1  sticky flag: a valid byte was dropped because the FIFO was full.
- err_count  output  ERR_CNT_W  saturating count of framing-error events.
- status_clr  input  1  clears overflow and err_count.

Behaviour:
- Reset: reset=1 on a clock edge clears the following.
  - Pointers and fifo_count go to 0.
  - out_valid=0, out_data=8'h00, fifo_full=0, overflow=0, err_count=0.
  - Reset takes effect mid-stream: stored bytes are lost, and any strobe in the reset cycle is ignored.
- Push condition: uart_valid=1 and uart_err=0.
  - uart_err=1 is a discard event whether or not uart_valid is also 1: nothing is written and err_count increments.
  - err_count saturates at all-ones and never wraps.
- Pop condition: out_valid=1 and out_ready=1.
- Storage is a circular buffer with read/write pointers of width $clog2(DEPTH). Pointers wrap from DEPTH-1 to 0.
- Output timing: first-word-fall-through, registered.
  - out_data/out_valid come from a registered head stage.
  - A byte pushed into an empty FIFO on edge N gives out_valid=1 and out_data equal to that byte after edge N+1 (latency 1 cycle).
  - out_data is stable while out_valid=1 and out_ready=0.
  - Back-to-back pops sustain one byte per cycle when data is available.
- fifo_count includes the byte held in the output register, so 0 ≤ fifo_count ≤ DEPTH.
  - fifo_full and the count are registered and update on the same edge as the push/pop.
- Simultaneous push and pop:
  - Any fill level: both happen and fifo_count is unchanged.
  - When full: the push is accepted, no overflow.
  - When fifo_count=1: the new byte becomes the head on the next cycle; out_valid stays 1 with no bubble.
- Push when full without pop: the byte is dropped, overflow is set to 1, and the stored contents are unchanged.
- status_clr:
  - overflow and err_count go to 0 on the next edge.
  - If an overflow or error event occurs in the same cycle, the event wins: overflow=1, err_count=1.
  - FIFO data is not affected.
- Order is preserved, with no duplication or loss apart from the documented drops.

Optional Feature:
- Macro UART_RX_FIFO_ERR_TAG_EN.
- Defined:
  - Storage is 9 bits wide and an extra output port out_err (1 bit, reset 0) is present.
  - An event with uart_valid=1 and uart_err=1 is pushed with tag=1 instead of discarded, and follows normal push/full/overflow rules.
  - err_count still increments.
  - uart_err=1 with uart_valid=0 is only counted.
- Undefined: errored bytes are discarded as above and out_err does not exist.

Decomposition:
- Package uart_pkg holds:
  - UART_DATA_W=8;
  - a function for the count width, $clog2(DEPTH)+1;
  - the tagged-entry struct typedef {err, data} used under UART_RX_FIFO_ERR_TAG_EN.
- One sub-module is natural: uart_fifo_mem, a DEPTH x width register array with a synchronous write port and an asynchronous read port, addressed by the pointers.
- Pointer, count and head-register control stays in uart_rx_fifo.

Test Plan:
- Reset, then push 8'h34 with one uart_valid strobe → out_valid=1 with out_data=8'h34 one cycle later, fifo_count=1; pop with out_ready=1 → out_valid=0, fifo_count=0.
- Push 8'h00..8'h0F (DEPTH=16) with out_ready=0 → fifo_full=1, fifo_count=16; push 8'hAA → overflow=1, count stays 16; drain → bytes read 8'h00..8'h0F in order, pointers wrap; refill 8'h55 → read back 8'h55.
- Hold out_ready=1 and push 8'h34, 8'h55, 8'h5A on consecutive cycles → three consecutive out_valid cycles with matching data and no bubble; count never exceeds 1.
- When full, push 8'hC3 and pop in the same cycle → no overflow, count stays 16, 8'hC3 appears last.
- Strobe uart_valid with uart_err=1 carrying 8'h77 → no push, err_count=1; 300 error strobes → err_count saturates at 255; status_clr → err_count=0, overflow=0. With UART_RX_FIFO_ERR_TAG_EN, 8'h77 is read back with out_err=1.
- Assert reset while 5 bytes are stored and a push is in flight → next cycle fifo_count=0, out_valid=0, overflow=0, and the in-flight byte is not stored.
